// File: rtl/divmod_pkg.sv
// -----------------------------------------------------------------------------
// divmod_pkg
//
// Shared types and constants for the sequential divide/modulo unit.
//
//   divmod_state_t : controller states (IDLE, CALC, DONE)
//   DIVMOD_N       : default operand/result width
//   cnt_width()    : width of the step counter for a given operand width
// -----------------------------------------------------------------------------
package divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divmod_state_t;

  localparam int unsigned DIVMOD_N = 4;

  // The step counter runs 0..N-1, so $clog2(N) bits are enough. N is at
  // least 2, which keeps the width at one bit or more.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : divmod_pkg

// File: rtl/divmod_step.sv
// -----------------------------------------------------------------------------
// divmod_step
//
// One restoring shift-subtract iteration, purely combinational. The next
// dividend bit (MSB of the quotient shift register) is shifted into the
// partial remainder. If the result is at least the divisor, the divisor is
// subtracted and a 1 enters the quotient. Otherwise a 0 enters the quotient.
//
// Ports:
//   pr       in  N+1  current partial remainder
//   q        in  N    quotient shift register (unconsumed dividend bits on top)
//   divisor  in  N    latched divisor
//   pr_next  out N+1  partial remainder after this step
//   q_next   out N    quotient shift register after this step
// -----------------------------------------------------------------------------
module divmod_step
  import divmod_pkg::*;
#(
  parameter int unsigned N = DIVMOD_N
) (
  input  logic [N:0]   pr,
  input  logic [N-1:0] q,
  input  logic [N-1:0] divisor,
  output logic [N:0]   pr_next,
  output logic [N-1:0] q_next
);

  logic [N:0] shifted;
  logic [N:0] divisor_ext;
  logic       fits;

  // The partial remainder always stays below the divisor, so its top bit is
  // zero on entry. Only the low N bits take part in the shift.
  logic unused_pr_msb;
  assign unused_pr_msb = pr[N];

  assign shifted     = {pr[N-1:0], q[N-1]};
  assign divisor_ext = {1'b0, divisor};
  assign fits        = (shifted >= divisor_ext);

  always_comb begin
    if (fits) begin
      pr_next = shifted - divisor_ext;
      q_next  = {q[N-2:0], 1'b1};
    end else begin
      pr_next = shifted;
      q_next  = {q[N-2:0], 1'b0};
    end
  end

endmodule : divmod_step

// File: rtl/seq_divmod_ctrl.sv
// -----------------------------------------------------------------------------
// seq_divmod_ctrl
//
// Multi-cycle unsigned divide/modulo unit with a start/done handshake.
// It uses restoring division and retires one quotient bit per clock.
// Results and the divide-by-zero flag are registered. They hold until the
// next result is written.
//
// Configuration macro:
//   SEQ_DIVMOD_FAST_PATH_EN - when defined, an accepted start with a nonzero
//   divisor and dividend < divisor writes quotient=0 and remainder=dividend
//   directly. It skips CALC, so done comes one edge after start.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   start      in   1  request, sampled only in IDLE or DONE
//   dividend   in   N  unsigned dividend, latched on accepted start
//   divisor    in   N  unsigned divisor, latched on accepted start
//   busy       out  1  high while the iteration is running (CALC)
//   done       out  1  one-cycle pulse, results valid from this cycle
//   quotient   out  N  registered quotient
//   remainder  out  N  registered remainder
//   error      out  1  registered, set when the last operation had divisor=0
// -----------------------------------------------------------------------------
module seq_divmod_ctrl
  import divmod_pkg::*;
#(
  parameter int unsigned N = DIVMOD_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         error
);

  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  divmod_state_t state_q, state_d;

  // Working registers for the iteration
  logic [N-1:0]  div_q, div_d;     // latched divisor
  logic [N:0]    pr_q, pr_d;       // partial remainder
  logic [N-1:0]  q_q, q_d;         // dividend in, quotient out (shift register)
  logic [CW-1:0] cnt_q, cnt_d;     // completed steps

  // Result registers
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          err_q, err_d;

  logic [N:0]    step_pr;
  logic [N-1:0]  step_q;

  divmod_step #(.N(N)) u_step (
    .pr      (pr_q),
    .q       (q_q),
    .divisor (div_q),
    .pr_next (step_pr),
    .q_next  (step_q)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop,
  // including the working registers, is cleared by reset, so an aborted
  // operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      pr_q    <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pr_q    <= pr_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a hold default before the case, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pr_d    = pr_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;

    unique case (state_q)
      // DONE accepts a new start exactly like IDLE, which allows back-to-back
      // operation without an idle cycle.
      IDLE, DONE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            err_d   = 1'b1;
            state_d = DONE;
          end
`ifdef SEQ_DIVMOD_FAST_PATH_EN
          else if (dividend < divisor) begin
            quo_d   = '0;
            rem_d   = dividend;
            err_d   = 1'b0;
            state_d = DONE;
          end
`endif
          else begin
            div_d   = divisor;
            pr_d    = '0;
            q_d     = dividend;
            cnt_d   = '0;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end

      // start and the operand inputs are not looked at here. A request during
      // the iteration neither restarts nor extends it.
      CALC: begin
        pr_d  = step_pr;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          quo_d   = step_q;
          rem_d   = step_pr[N-1:0];
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q == CALC);
    done      = (state_q == DONE);
    quotient  = quo_q;
    remainder = rem_q;
    error     = err_q;
  end

endmodule : seq_divmod_ctrl

// File: tb/tb_seq_divmod_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_divmod_ctrl
//
// Self-checking bench for seq_divmod_ctrl at N=4. Table-driven vectors with
// hand-computed results run back to back, followed by hand-written corner
// sequences (start during CALC, reset during CALC) and random operations
// against a reference model. Expected results go into a scoreboard queue when
// a start is driven and are popped when done is observed.
// -----------------------------------------------------------------------------
module tb_seq_divmod_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         error;

  seq_divmod_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         e;
  } vec_t;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         e;
    int           lat;
    int           busy_cycles;
  } exp_t;

  exp_t         sb[$];
  vec_t         tbl[10];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] last_q = '0;
  logic [N-1:0] last_r = '0;
  logic         last_e = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) return 1;
`ifdef SEQ_DIVMOD_FAST_PATH_EN
    if (a < b) return 1;
`endif
    return N + 1;
  endfunction

  function automatic exp_t mk_exp(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic [N-1:0] q, input logic [N-1:0] r,
                                  input logic e);
    exp_t x;
    x.q           = q;
    x.r           = r;
    x.e           = e;
    x.lat         = exp_lat(a, b);
    x.busy_cycles = (x.lat == 1) ? 0 : N;
    return x;
  endfunction

  // Reference model for random operations.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) return mk_exp(a, b, '1, a, 1'b1);
    return mk_exp(a, b, a / b, a % b, 1'b0);
  endfunction

  // Called at a negedge. Drives the request for one edge (E0) and pushes the
  // expectation. The operand inputs are scrambled afterwards, which must not
  // disturb the running operation.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input exp_t x);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(x);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
  endtask

  // Waits for done, counting edges since E0 and busy cycles. Checks that the
  // previous result is held while the iteration runs. When glitch_edge is
  // nonzero, a second start is pulsed during that cycle. Returns at the
  // negedge where done is seen.
  task automatic wait_done(input int glitch_edge, output int lat, output int busy_cnt);
    int edges;
    edges    = 1;
    busy_cnt = 0;
    lat      = -1;
    forever begin
      @(negedge clk);
      if (done) begin
        lat = edges;
        break;
      end
      if (busy) begin
        busy_cnt++;
        check("hold_during_calc", {quotient, remainder, error}, {last_q, last_r, last_e});
      end
      if (edges == glitch_edge) begin
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
      end else begin
        start = 1'b0;
      end
      if (edges > 20) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: no done within %0d edges", edges);
        break;
      end
      @(posedge clk);
      edges++;
    end
    start = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int glitch_edge);
    int   lat;
    int   bc;
    exp_t x;
    wait_done(glitch_edge, lat, bc);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: done with empty queue", tag);
    end else begin
      x = sb.pop_front();
      check({tag, "_quotient"},  32'(quotient),  32'(x.q));
      check({tag, "_remainder"}, 32'(remainder), 32'(x.r));
      check({tag, "_error"},     32'(error),     32'(x.e));
      check({tag, "_latency"},   32'(lat),       32'(x.lat));
      check({tag, "_busy"},      32'(bc),        32'(x.busy_cycles));
      last_q = x.q;
      last_r = x.r;
      last_e = x.e;
    end
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    int           seen_done;

    tbl[0] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0};
    tbl[1] = '{4'd7,  4'd3,  4'd2,  4'd1, 1'b0};
    tbl[2] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
    tbl[3] = '{4'd6,  4'd0,  4'd15, 4'd6, 1'b1};
    tbl[4] = '{4'd6,  4'd3,  4'd2,  4'd0, 1'b0};
    tbl[5] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
    tbl[6] = '{4'd3,  4'd9,  4'd0,  4'd3, 1'b0};
    tbl[7] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
    tbl[8] = '{4'd15, 4'd2,  4'd7,  4'd1, 1'b0};
    tbl[9] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_done",      32'(done),      32'd0);
    check("reset_quotient",  32'(quotient),  32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_error",     32'(error),     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, each started in the DONE cycle of the previous one
    for (int i = 0; i < 10; i++) begin
      start_op(tbl[i].a, tbl[i].b,
               mk_exp(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].e));
      finish_op($sformatf("vec%0d", i), 0);
    end

    // done is a single-cycle pulse, and with no start the unit returns to idle
    @(negedge clk);
    check("done_pulse_width", 32'(done), 32'd0);
    check("idle_busy",        32'(busy), 32'd0);
    check("idle_hold_q",      32'(quotient), 32'(last_q));

    // A start pulse during CALC is ignored
    start_op(4'd13, 4'd4, mk_exp(4'd13, 4'd4, 4'd3, 4'd1, 1'b0));
    finish_op("ignore_start", 2);

    // Random operations against the model
    for (int i = 0; i < 20; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      start_op(ra, rb, model(ra, rb));
      finish_op($sformatf("rnd%0d", i), 0);
    end

    // Reset at the second CALC edge aborts the operation
    @(negedge clk);
    start_op(4'd14, 4'd3, mk_exp(4'd14, 4'd3, 4'd4, 4'd2, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_done",      32'(done),      32'd0);
    check("abort_quotient",  32'(quotient),  32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_error",     32'(error),     32'd0);
    rst = 1'b0;
    sb.delete();
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_divmod_ctrl
